side_buf_ctrl: RTL

- Control/sequencing block for the minBD side buffer: owns the write/read pointers, occupancy count, full/empty flags and the starvation monitor.
- Selects which write source (redirect stage or eject-to-side-buffer stage) owns the single buffer write port each cycle, and advances the read pointer on side-buffer injection grants.
- Drives an external flit storage array (register file) through wr_en/wr_sel/wr_addr/rd_addr.
- Its full/empty/starve outputs feed the redirect, eject-to-side-buffer and side-buffer inject stages.

---
 rtl/side_buf_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/side_buf_ctrl.sv
// Side buffer control for the minBD router: owns the read/write pointers,
// occupancy count, full/empty flags and the head-flit starvation monitor,
// and arbitrates the single storage write port between the redirect stage
// and the eject-to-side-buffer stage. Flit data lives in an external array
// addressed through wr_addr/rd_addr.
module side_buf_ctrl #(
    parameter int DEPTH     = 4,
    parameter int AW        = $clog2(DEPTH),
    parameter int STARVE_TH = 8,
    parameter int SW        = $clog2(STARVE_TH + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          redirect_req,
    input  logic          eject_req,
    input  logic          inject_gnt,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          starve,
    output logic          err_ovf,
    output logic          err_drop
);

    // Occupancy at which the buffer is full, last valid index before wrap,
    // and the saturation point of the starvation counter.
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_TH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [SW-1:0] starve_cnt;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          collide;
    logic          ovf_attempt;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_next;
    logic [SW-1:0] starve_cnt_next;

    // Flags come straight from the registered count; no same-cycle bypass.
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;

    // Write-port arbitration and push/pop acceptance. Redirect always wins a
    // collision; a full buffer still accepts a push when the head leaves in
    // the same cycle because a slot frees up at the same edge.
    always_comb begin
        push_req    = redirect_req | eject_req;
        collide     = redirect_req & eject_req;
        pop         = inject_gnt & ~empty;
        push        = push_req & (~full | pop);
        ovf_attempt = push_req & full & ~pop;
        wr_en       = push;
        wr_sel      = eject_req & ~redirect_req;
    end

    // Next pointer, occupancy and starvation values. Pointers wrap explicitly
    // so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_next     = wr_ptr;
        rd_ptr_next     = rd_ptr;
        count_next      = count_q;
        starve_cnt_next = starve_cnt;

        if (push) begin
            wr_ptr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase

        if (empty || pop) begin
            starve_cnt_next = '0;
        end else if (starve_cnt == STARVE_MAX) begin
            starve_cnt_next = STARVE_MAX;
        end else begin
            starve_cnt_next = starve_cnt + 1'b1;
        end
    end

    // State registers; errors are sticky until the next reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            starve_cnt <= '0;
            starve     <= 1'b0;
            err_ovf    <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count_q    <= count_next;
            starve_cnt <= starve_cnt_next;
            starve     <= (starve_cnt_next == STARVE_MAX);
            err_ovf    <= err_ovf | ovf_attempt;
            err_drop   <= err_drop | collide;
        end
    end

endmodule
